// File: rtl/jtcastle_romcache_pkg.sv
// Shared types for the CPU ROM line cache: FSM encoding, hit latency and byte lane select.
package jtcastle_romcache_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SETTLE} state_e;

  // Tag/data array has a registered read, so a hit needs the read edge plus the ok edge
  localparam int HIT_LAT = 2;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/jtcastle_romcache_mem.sv
// Tag+data line store: one write port for refills, one registered read port for lookups.
module jtcastle_romcache_mem #(
  parameter int IW = 4,
  parameter int LW = 44
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [LW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [LW-1:0] rdata_o
);

  logic [LW-1:0] mem [0:(1<<IW)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/jtcastle_romcache.sv
// Direct-mapped 4-byte-line read cache between the CPU ROM port and an SDRAM ROM slot.
module jtcastle_romcache
  import jtcastle_romcache_pkg::*;
#(
  parameter int AW = 18,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic          mem_cs,
  output logic [AW-3:0] mem_addr,
  input  logic [31:0]   mem_data,
  input  logic          mem_ok
);

  localparam int TW = AW - IW - 2;
  localparam int LW = TW + 32;
  localparam int NL = 1 << IW;

  state_e        st_q, st_d;
  logic [NL-1:0] valid_q, valid_d;
  logic          ok_q, ok_d;
  logic [AW-1:0] addr_r_q, addr_r_d;
  logic [7:0]    data_q, data_d;
  logic          mem_cs_q, mem_cs_d;
  logic [AW-3:0] mem_addr_q, mem_addr_d;
  logic          fl_q, fl_d;
  logic          look_cs_q;
  logic [AW-1:0] look_addr_q;

  logic [LW-1:0] rdata;
  logic [TW-1:0] rd_tag, look_tag;
  logic [31:0]   rd_word;
  logic [IW-1:0] look_idx, fill_idx;
  logic          fill_we, killed;

  // Lookup address trails the array read by one edge so tag and address line up
  assign look_idx = look_addr_q[IW+1:2];
  assign look_tag = look_addr_q[AW-1:IW+2];
  assign rd_tag   = rdata[LW-1:32];
  assign rd_word  = rdata[31:0];
  assign fill_idx = mem_addr_q[IW-1:0];
  assign fill_we  = (st_q == ST_FILL) && mem_ok;
  assign killed   = flush | fl_q;

  jtcastle_romcache_mem #(.IW(IW), .LW(LW)) u_mem (
    .clk     (clk),
    .we_i    (fill_we),
    .waddr_i (fill_idx),
    .wdata_i ({mem_addr_q[AW-3:IW], mem_data}),
    .raddr_i (rom_addr[IW+1:2]),
    .rdata_o (rdata)
  );

  always_comb begin
    st_d       = st_q;
    valid_d    = valid_q;
    ok_d       = ok_q;
    addr_r_d   = addr_r_q;
    data_d     = data_q;
    mem_cs_d   = mem_cs_q;
    mem_addr_d = mem_addr_q;
    fl_d       = fl_q;
    case (st_q)
      ST_IDLE: begin
        // Only act once the registered lookup refers to the address still on the bus
        if (!flush && rom_cs && look_cs_q && look_addr_q == rom_addr) begin
          if (valid_q[look_idx] && rd_tag == look_tag) begin
            data_d   = byte_sel(rd_word, look_addr_q[1:0]);
            addr_r_d = look_addr_q;
            ok_d     = 1'b1;
          end else begin
            st_d       = ST_FILL;
            mem_cs_d   = 1'b1;
            mem_addr_d = look_addr_q[AW-1:2];
            ok_d       = 1'b0;
            fl_d       = 1'b0;
          end
        end
      end
      ST_FILL: begin
        if (flush) fl_d = 1'b1;
        if (mem_ok) begin
          mem_cs_d = 1'b0;
          st_d     = ST_SETTLE;
          if (!killed) begin
            valid_d[fill_idx] = 1'b1;
            if (rom_addr[AW-1:2] == mem_addr_q) begin
              data_d   = byte_sel(mem_data, rom_addr[1:0]);
              addr_r_d = rom_addr;
              ok_d     = 1'b1;
            end
          end
        end
      end
      ST_SETTLE: st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
      ok_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      valid_q     <= '0;
      ok_q        <= 1'b0;
      addr_r_q    <= '0;
      data_q      <= '0;
      mem_cs_q    <= 1'b0;
      mem_addr_q  <= '0;
      fl_q        <= 1'b0;
      look_cs_q   <= 1'b0;
      look_addr_q <= '0;
    end else begin
      st_q        <= st_d;
      valid_q     <= valid_d;
      ok_q        <= ok_d;
      addr_r_q    <= addr_r_d;
      data_q      <= data_d;
      mem_cs_q    <= mem_cs_d;
      mem_addr_q  <= mem_addr_d;
      fl_q        <= fl_d;
      look_cs_q   <= rom_cs;
      look_addr_q <= rom_addr;
    end
  end

  assign rom_data = data_q;
  assign rom_ok   = ok_q & rom_cs & (addr_r_q == rom_addr);
  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_jtcastle_romcache.sv
// Scoreboard bench for jtcastle_romcache: line-level cache model, SDRAM responder, ok monitor.
module tb_jtcastle_romcache;
  import jtcastle_romcache_pkg::*;

  localparam int AW = 18;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          rom_cs = 1'b0;
  logic [AW-1:0] rom_addr = '0;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          mem_cs;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_data = '0;
  logic          mem_ok = 1'b0;

  jtcastle_romcache #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ok(mem_ok)
  );

  always #10 clk = ~clk;

  typedef struct { int addr; int data; bit hit; int t; } exp_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int issued = 0, checked = 0;
  int lat_cfg = 3;
  int n_req = 0;
  logic [31:0] rom_img [65536];
  exp_t sbq[$];
  int fillq[$];
  bit mv[16];
  int mt[16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // SDRAM slot: fixed latency per request, keeps serving across a CPU-side reset
  initial begin : sdram
    bit busy = 0, just_ok = 0;
    int cnt = 0, waddr = 0;
    forever begin
      @(negedge clk);
      mem_ok = 1'b0;
      mem_data = $urandom;
      if (just_ok) check("mem_cs_drop", int'(mem_cs), 0);
      just_ok = 0;
      if (busy) begin
        if (mem_cs) check("mem_addr_hold", int'(mem_addr), waddr);
        if (cnt == 0) begin
          mem_ok = 1'b1; mem_data = rom_img[waddr]; busy = 0; just_ok = 1;
        end else cnt--;
      end else if (mem_cs) begin
        n_req++; busy = 1; waddr = int'(mem_addr); cnt = lat_cfg - 1;
        if (fillq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_fill: mem_addr 0x%0h, expected no request", mem_addr);
        end else check("fill_addr", int'(mem_addr), fillq.pop_front());
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit have_last = 0;
    int last_a = 0, last_d = 0;
    forever begin
      @(negedge clk); #1;
      if (rom_ok) begin
        if (checked < issued) begin
          e = sbq.pop_front();
          check("rom_data", int'(rom_data), e.data);
          if (e.hit) check("hit_latency", cyc - e.t, HIT_LAT);
          last_a = e.addr; last_d = e.data; have_last = 1;
          checked++;
        end else if (have_last && int'(rom_addr) == last_a) begin
          check("held_data", int'(rom_data), last_d);
        end else begin
          n_tests++; n_fail++;
          $display("FAIL spurious_ok: rom_ok=1 at 0x%0h data 0x%0h, expected 0", rom_addr, rom_data);
        end
      end
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endfunction

  // Model a CPU read: predicts hit/miss, the refill line and the byte returned
  task automatic issue(input int a);
    int idx, tg;
    exp_t e;
    rom_cs = 1'b1;
    rom_addr = a[AW-1:0];
    idx = (a / 4) % 16;
    tg  = a / 64;
    e.hit = mv[idx] && mt[idx] == tg;
    if (!e.hit) begin
      fillq.push_back(a / 4);
      mv[idx] = 1; mt[idx] = tg;
    end
    e.addr = a;
    e.data = int'((rom_img[a / 4] >> (8 * (a % 4))) & 32'hFF);
    e.t = cyc;
    sbq.push_back(e);
    issued++;
  endtask

  task automatic wait_done();
    int w = 0;
    while (checked != issued) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        n_tests++; n_fail++;
        $display("FAIL read_timeout: %0d of %0d reads answered", checked, issued);
        summary();
      end
    end
  endtask

  task automatic do_read(input int a);
    @(negedge clk);
    issue(a);
    wait_done();
  endtask

  task automatic wait_mem_cs();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
      if (w > 40) begin
        n_tests++; n_fail++;
        $display("FAIL mem_cs_timeout: mem_cs=0 after %0d cycles, expected 1", w);
        summary();
      end
    end while (!mem_cs);
  endtask

  // Flush with rom_cs held, then park rom_cs low so no refill starts unannounced
  task automatic do_flush(input int n);
    @(negedge clk);
    flush = 1'b1;
    repeat (n) @(negedge clk);
    check("flush_ok", int'(rom_ok), 0);
    flush = 1'b0;
    rom_cs = 1'b0;
    model_clear();
  endtask

  initial begin : stim
    int r0, a, prev;
    int bases[4];
    bases[0] = 'h00000; bases[1] = 'h08000; bases[2] = 'h20000; bases[3] = 'h3FFC0;
    for (int i = 0; i < 65536; i++) rom_img[i] = $urandom;
    rom_img[16'h2000] = 32'h44332211;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_rom_data", int'(rom_data), 0);
    check("rst_rom_ok", int'(rom_ok), 0);
    check("rst_mem_cs", int'(mem_cs), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    rst_n = 1'b1;

    // cold read, then same-line hits
    lat_cfg = 5; r0 = n_req;
    do_read('h08002);
    check("cold_fills", n_req - r0, 1);
    r0 = n_req;
    do_read('h08000); do_read('h08001); do_read('h08003);
    check("line_hit_fills", n_req - r0, 0);

    // conflict eviction on one index
    do_flush(1); r0 = n_req;
    do_read('h08000); do_read('h08040); do_read('h08000);
    check("conflict_fills", n_req - r0, 3);

    // top address lands on the last index, conflicting with 0x0003C
    do_flush(1); lat_cfg = 2; r0 = n_req;
    do_read('h3FFFF); do_read('h0003C); do_read('h3FFFC);
    check("wrap_fills", n_req - r0, 3);

    // address moves while the fill is outstanding
    do_flush(2); lat_cfg = 6; r0 = n_req;
    @(negedge clk);
    rom_cs = 1'b1; rom_addr = 'h10000;
    fillq.push_back('h10000 / 4);
    mv[0] = 1; mt[0] = 'h10000 / 64;
    wait_mem_cs();
    @(negedge clk);
    issue('h20000);
    wait_done();
    check("moved_fills", n_req - r0, 2);

    // flush then re-read must refetch
    do_read('h08002);
    do_flush(1); r0 = n_req;
    do_read('h08002);
    check("flush_refetch", n_req - r0, 1);

    // flush coincident with mem_ok: line left invalid, refilled by the held read
    do_flush(1); lat_cfg = 3; r0 = n_req;
    @(negedge clk);
    issue('h08002);
    fillq.push_back('h08002 / 4);
    wait_mem_cs();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_done();
    check("flush_on_ok_fills", n_req - r0, 2);

    // reset mid-fill, stray mem_ok afterwards
    do_flush(1); lat_cfg = 8; r0 = n_req;
    @(negedge clk);
    rom_cs = 1'b1; rom_addr = 'h30004;
    fillq.push_back('h30004 / 4);
    wait_mem_cs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_cs", int'(mem_cs), 0);
    check("rst_mid_rom_ok", int'(rom_ok), 0);
    check("rst_mid_rom_data", int'(rom_data), 0);
    rom_cs = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("stray_mem_cs", int'(mem_cs), 0);
    end
    do_read('h30004);
    check("post_rst_refetch", n_req - r0, 2);

    // randomized traffic over four conflicting tags
    prev = 'h30004;
    for (int i = 0; i < 150; i++) begin
      lat_cfg = int'($urandom_range(1, 6));
      if ($urandom_range(0, 19) == 0) begin
        do_flush(int'($urandom_range(1, 3)));
        prev = -1;
      end
      do begin
        a = bases[$urandom_range(0, 3)] | int'($urandom_range(0, 15) << 2) | int'($urandom_range(0, 3));
      end while (a == prev);
      do_read(a);
      prev = a;
    end

    repeat (10) @(negedge clk);
    check("fillq_empty", fillq.size(), 0);
    check("sbq_empty", sbq.size(), 0);
    summary();
  end

endmodule
